csa_mod_reduce: RTL and testbench
=================================

Name: csa_mod_reduce

Overview:
- Consumes the final carry-propagate sum of the 12-operand carry-save tree, extended to N+EXT bits.
- Reduces that sum modulo q to a canonical value in [0, q).
- Structure: fully pipelined binary-descent conditional-subtract chain, one registered stage per bit of EXT.
- Valid/ready handshake, so the NTT datapath can stall it without losing data.

Parameters:
- N, 64, width of modulus and of reduced output.
- EXT, 4, extra headroom bits on the input; input contract x < (2^EXT)*q; also the number of pipeline stages.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- q  input  N  modulus; q >= 1, q < 2^N; held stable while any valid data is in flight.
- in_valid  input  1  in_data valid this cycle.
- in_ready  output  1  block accepts in_data this cycle.
- in_data  input  N+EXT  unreduced sum x.
- out_valid  output  1  out_data valid.
- out_ready  input  1  consumer accepts out_data this cycle.
- out_data  output  N  x mod q.

Behaviour:
- Pipeline: stages s = 0..EXT-1. Stage s uses k = EXT-1-s.
  - Stage input y: if y >= (q << k), register y - (q << k); else register y.
  - Stage 0 input is in_data.
  - Compare and subtract use full N+EXT width; q << k is zero-extended to N+EXT before shifting, so no truncation.
- Each stage has a data register (N+EXT bits) and a valid bit.
- out_data = low N bits of the last stage's data register; out_valid = last stage's valid bit.
- Global enable: en = !out_valid || out_ready; in_ready = en (combinational).
  - en=1: every stage loads from its predecessor. Stage 0 loads in_data and valid = in_valid.
  - en=0: every data register and valid bit holds.
  - Bubbles are not collapsed.
- Latency: with en high throughout, an input accepted at edge t (in_valid && in_ready) appears with out_valid=1 after edge t+EXT-1, i.e. EXT cycles of register delay. Throughput is one result per cycle.
- Stall hold: while out_valid && !out_ready, out_data and out_valid stay stable, and in_ready=0.
- Input discipline: in_valid while in_ready=0 is ignored. The upstream stage holds in_data and in_valid until accepted.
- Reset: rst_n low asynchronously clears all valid bits and data registers to 0. While in reset, out_valid=0, out_data=0, in_ready=1. Reset mid-operation discards all in-flight data. The first edge after deassertion behaves as an empty pipeline.
- In-contract arithmetic (x < 2^EXT * q): after stage s the value is < (q << k). Final out_data < q and equals x mod q exactly.
- Out of contract (x >= 2^EXT * q): out_data = low N bits of the chain result. Timing and handshake are unchanged. No error flag.
- Boundaries:
  - x=0 -> 0.
  - x=q -> 0.
  - x = m*q for m < 2^EXT -> 0.
  - x = 2^EXT*q - 1 -> q-1.
  - x = q-1 -> q-1, no subtraction taken.
  - Equality at any stage (y == q << k) takes the subtraction.
- Simultaneous in_valid with out_ready falling: out_ready is sampled on the same edge. If out_valid && !out_ready at that edge, the input is not accepted.

Test Plan:
- Streaming, N=64, EXT=4, q=0xFFFFFFFF00000001, out_ready=1. Inputs 0, q, 15*q, 16*q-1, q-1 on consecutive cycles -> out_valid high starting 4 cycles after the first accept. Outputs 0, 0, 0, q-1, q-1, back to back, no gaps.
- Equality at each stage: x = 8q, 4q, 2q, 1q, and 8q+4q+2q+q+5 -> 0, 0, 0, 0, 5.
- Backpressure: stream 10 random in-contract values; drop out_ready for 3 cycles while out_valid=1. Required: in_ready=0 during the stall, out_data frozen, no value lost or duplicated. All 10 outputs match a reference x mod q, in order.
- Bubbles: in_valid pattern 1,0,1,0,0,1 with x = 17, 5q+3, 0 (q=97) -> out_valid pattern is the same delayed by 4 cycles; data 17, 3, 0.
- Reset mid-flight: accept 3 values, assert rst_n low for 1 cycle asynchronously between edges. out_valid=0 and out_data=0 immediately; none of the 3 values ever appear. A fresh input x=200 (q=97) yields 6 after 4 cycles.
- Small modulus q=1: any in-contract x < 16 -> 0. Out-of-contract x=0x40 with q=1 -> 0x40 - 15 = 0x31, timing unchanged.

Source files
------------

// File: rtl/csa_mod_reduce_if.sv
// rtl/csa_mod_reduce_if.sv - handshake bundle for the modular reduction pipeline
//
// Purpose: groups the input and output valid/ready streams of csa_mod_reduce.
// Signals:
//   in_valid  - upstream has in_data this cycle
//   in_ready  - reducer accepts in_data this cycle
//   in_data   - unreduced sum x, N+EXT bits
//   out_valid - out_data holds a result
//   out_ready - downstream accepts out_data this cycle
//   out_data  - x mod q, N bits
// Modports: master = producer/consumer side (testbench, NTT datapath),
//           slave  = the reducer itself.
interface csa_mod_reduce_if #(
  parameter int N   = 64,
  parameter int EXT = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [N+EXT-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/csa_mod_reduce.sv
// rtl/csa_mod_reduce.sv - pipelined binary-descent reduction of a CSA sum modulo q
//
// Purpose: reduces x (N+EXT bits, x < 2^EXT * q) to x mod q with one registered
// conditional-subtract stage per headroom bit. Stage s subtracts q << (EXT-1-s)
// when its input is at least that large, so the residue range halves each stage.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset, clears all stage data and valid bits
//   q     - modulus, held stable while data is in flight
//   bus   - csa_mod_reduce_if.slave: in_valid/in_ready/in_data, out_valid/out_ready/out_data
module csa_mod_reduce #(
  parameter int N   = 64,
  parameter int EXT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     q,
  csa_mod_reduce_if.slave  bus
);
  localparam int W = N + EXT;

  logic [W-1:0]   data_r    [EXT];
  logic [EXT-1:0] valid_r;
  logic [W-1:0]   stage_nxt [EXT];
  logic           en;

  // Single global enable: the whole chain advances or the whole chain holds.
  // Bubbles travel with the data rather than being squeezed out.
  assign en           = !valid_r[EXT-1] || bus.out_ready;
  assign bus.in_ready = en;
  assign bus.out_valid = valid_r[EXT-1];
  assign bus.out_data  = data_r[EXT-1][N-1:0];

  for (genvar s = 0; s < EXT; s++) begin : g_stage
    localparam int K = EXT - 1 - s;
    logic [W-1:0] y;
    logic [W-1:0] qk;

    if (s == 0) begin : g_first
      assign y = bus.in_data;
    end else begin : g_rest
      assign y = data_r[s-1];
    end

    // q is widened before the shift so the top bits of q << K are kept.
    assign qk           = {{EXT{1'b0}}, q} << K;
    // Equality takes the subtraction, leaving a residue strictly below q << K.
    assign stage_nxt[s] = (y >= qk) ? (y - qk) : y;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= '0;
      for (int s = 0; s < EXT; s++) begin
        data_r[s] <= '0;
      end
    end else if (en) begin
      valid_r[0] <= bus.in_valid;
      for (int s = 1; s < EXT; s++) begin
        valid_r[s] <= valid_r[s-1];
      end
      for (int s = 0; s < EXT; s++) begin
        data_r[s] <= stage_nxt[s];
      end
    end
  end
endmodule

// File: tb/tb_csa_mod_reduce.sv
// tb/tb_csa_mod_reduce.sv - randomized self-checking bench for csa_mod_reduce
module tb_csa_mod_reduce;
  localparam int N   = 64;
  localparam int EXT = 4;
  localparam logic [63:0] QG = 64'hFFFF_FFFF_0000_0001;

  logic        clk;
  logic        rst_n;
  logic [N-1:0] q;

  csa_mod_reduce_if #(.N(N), .EXT(EXT)) bus_if ();

  csa_mod_reduce #(.N(N), .EXT(EXT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .q     (q),
    .bus   (bus_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [127:0] val;
    int           cyc;
  } exp_t;

  exp_t         exp_q[$];
  int           n_checks = 0;
  int           n_fail   = 0;
  int           cyc      = 0;
  bit           chk_lat  = 1'b1;
  bit           ovr_en   = 1'b0;
  logic [127:0] ovr_val  = '0;
  bit           stall_prev = 1'b0;
  logic [N-1:0] prev_data  = '0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain modular arithmetic on wide integers.
  function automatic logic [127:0] ref_mod(input logic [127:0] x, input logic [63:0] qq);
    logic [127:0] qw;
    qw = {64'd0, qq};
    return x % qw;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: sampled on the falling edge; a transfer seen here completes on the next rising edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (stall_prev) begin
        check("hold_valid", {127'd0, bus_if.out_valid}, 128'd1);
        check("hold_data", {64'd0, bus_if.out_data}, {64'd0, prev_data});
      end
      if (bus_if.out_valid && !bus_if.out_ready)
        check("stall_in_ready", {127'd0, bus_if.in_ready}, 128'd0);
      if (bus_if.out_valid && bus_if.out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", {64'd0, bus_if.out_data}, 128'hDEAD);
        end else begin
          e = exp_q.pop_front();
          check("data", {64'd0, bus_if.out_data}, e.val);
          if (chk_lat) check("latency", 128'(cyc - e.cyc), 128'(EXT));
        end
      end
      if (bus_if.in_valid && bus_if.in_ready) begin
        e.val = ovr_en ? ovr_val : ref_mod({60'd0, bus_if.in_data}, q);
        e.cyc = cyc;
        exp_q.push_back(e);
      end
      stall_prev = bus_if.out_valid && !bus_if.out_ready;
      prev_data  = bus_if.out_data;
    end else begin
      stall_prev = 1'b0;
    end
  end

  // Drive x and hold it until accepted; returns at 1 time unit after the accepting edge.
  task automatic put(input logic [127:0] x);
    bit ok;
    bit done;
    done = 1'b0;
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = x[N+EXT-1:0];
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      ok = bus_if.in_ready;
      @(posedge clk);
      #1;
      done = ok;
    end
    if (!done) check("accept_timeout", 128'd0, 128'd1);
    bus_if.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bus_if.in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && exp_q.size() > 0; i++) begin
      @(posedge clk);
      #1;
    end
    check("drain", 128'(exp_q.size()), 128'd0);
    idle(2);
  endtask

  initial begin
    logic [127:0] x;
    logic [127:0] qw;
    rst_n = 1'b0;
    q = 64'd97;
    bus_if.in_valid  = 1'b0;
    bus_if.in_data   = '0;
    bus_if.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {127'd0, bus_if.out_valid}, 128'd0);
    check("rst_out_data", {64'd0, bus_if.out_data}, 128'd0);
    check("rst_in_ready", {127'd0, bus_if.in_ready}, 128'd1);
    rst_n = 1'b1;
    idle(1);

    // Streaming boundaries with the Goldilocks-style modulus.
    q  = QG;
    qw = {64'd0, QG};
    put(128'd0);
    put(qw);
    put(qw * 15);
    put(qw * 16 - 1);
    put(qw - 1);
    drain();

    // Equality at each stage.
    put(qw * 8);
    put(qw * 4);
    put(qw * 2);
    put(qw);
    put(qw * 15 + 5);
    drain();

    // Backpressure with random in-contract values.
    q = {$urandom(), $urandom()} | 64'd1;
    qw = {64'd0, q};
    chk_lat = 1'b0;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          x = {32'd0, $urandom(), $urandom(), $urandom()} % (qw << EXT);
          put(x);
        end
      end
      begin
        for (int i = 0; i < 200 && !bus_if.out_valid; i++) begin
          @(posedge clk);
          #1;
        end
        bus_if.out_ready = 1'b0;
        repeat (3) begin
          @(posedge clk);
          #1;
        end
        bus_if.out_ready = 1'b1;
      end
    join
    drain();
    chk_lat = 1'b1;

    // Random streaming with moduli of varied size.
    for (int j = 0; j < 3; j++) begin
      q = (j == 0) ? 64'd3 : ((j == 1) ? 64'(32'($urandom()) | 32'd1) : ({$urandom(), $urandom()} | 64'd1));
      qw = {64'd0, q};
      for (int i = 0; i < 8; i++) begin
        x = {32'd0, $urandom(), $urandom(), $urandom()} % (qw << EXT);
        put(x);
      end
      drain();
    end

    // Bubbles: valid pattern 1,0,1,0,0,1.
    q = 64'd97;
    put(128'd17);
    idle(1);
    put(128'd97 * 5 + 3);
    idle(2);
    put(128'd0);
    drain();

    // Reset mid-flight: three values in the pipe, first one already at the output.
    put(128'd10);
    put(128'd20);
    put(128'd30);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {127'd0, bus_if.out_valid}, 128'd0);
    check("midrst_out_data", {64'd0, bus_if.out_data}, 128'd0);
    check("midrst_in_ready", {127'd0, bus_if.in_ready}, 128'd1);
    exp_q.delete();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    put(128'd200);
    drain();

    // Modulus of one, including an out-of-contract input.
    q = 64'd1;
    put(128'd0);
    put(128'd7);
    put(128'd15);
    ovr_en  = 1'b1;
    ovr_val = 128'h31;
    put(128'h40);
    ovr_en  = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
